// File: rtl/sys_arr_pkg.sv
// -----------------------------------------------------------------------------
// sys_arr_pkg
// Shared constants and types for the systolic-array result path.
//   DATA_W / ADDR_W / DEPTH : result word width, buffer address width, entries
//   cnt_t                   : drain length counter, wide enough to hold DEPTH
//   drain_state_t           : drain FSM states
//   sat_count()             : clamps a requested drain length to DEPTH
// -----------------------------------------------------------------------------
package sys_arr_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int CNT_W  = ADDR_W + 1;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } drain_state_t;

  // A request longer than the buffer drains every entry exactly once.
  function automatic cnt_t sat_count(input cnt_t count);
    return (count > cnt_t'(DEPTH)) ? cnt_t'(DEPTH) : count;
  endfunction

endpackage

// File: rtl/output_result_buffer_if.sv
// -----------------------------------------------------------------------------
// output_result_buffer_if
// Valid/ready stream carrying drained results toward the host/memory writer.
//   out_valid     : out_data/out_addr/out_entry_vld are valid
//   out_ready     : downstream accepts the word this cycle
//   out_data      : drained result word
//   out_addr      : buffer address the word came from
//   out_entry_vld : entry held a written result when it was loaded
// master = buffer side, slave = consumer side.
// -----------------------------------------------------------------------------
interface output_result_buffer_if;
  import sys_arr_pkg::*;

  logic  out_valid;
  logic  out_ready;
  data_t out_data;
  addr_t out_addr;
  logic  out_entry_vld;

  modport master (
    output out_valid, out_data, out_addr, out_entry_vld,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_addr, out_entry_vld,
    output out_ready
  );

endinterface

// File: rtl/output_buffer_mem.sv
// -----------------------------------------------------------------------------
// output_buffer_mem
// DEPTH x DATA_W result storage plus a per-entry valid vector.
//   clk, rst       : clock, synchronous active-low reset (valid vector only)
//   i_wr_*         : write port; sets the entry's valid bit
//   i_clr_en/addr  : clears a valid bit; a same-edge write to it wins
//   i_rd_addr      : asynchronous read address
//   o_rd_data/vld  : word and valid bit at i_rd_addr (pre-edge contents)
//   o_valid_bits   : full valid vector
//   o_overwrite    : one-cycle pulse, last write hit an already-valid entry
// -----------------------------------------------------------------------------
module output_buffer_mem
  import sys_arr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  addr_t            i_wr_addr,
  input  data_t            i_wr_data,
  input  logic             i_clr_en,
  input  addr_t            i_clr_addr,
  input  addr_t            i_rd_addr,
  output data_t            o_rd_data,
  output logic             o_rd_vld,
  output logic [DEPTH-1:0] o_valid_bits,
  output logic             o_overwrite
);

  data_t            r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic             r_overwrite;

  // NOTE: the data array has no reset; the valid vector says which entries
  // mean anything, so clearing storage would only cost reset fan-out.
  // Writes are still blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst && i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge
  // values. With two non-blocking writes to the same bit, the later one
  // takes effect, which gives the write-over-clear priority below.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid     <= '0;
      r_overwrite <= 1'b0;
    end else begin
      r_overwrite <= i_wr_en & r_valid[i_wr_addr];
      if (i_clr_en) begin
        r_valid[i_clr_addr] <= 1'b0;
      end
      if (i_wr_en) begin
        r_valid[i_wr_addr] <= 1'b1;
      end
    end
  end

  assign o_rd_data    = r_mem[i_rd_addr];
  assign o_rd_vld     = r_valid[i_rd_addr];
  assign o_valid_bits = r_valid;
  assign o_overwrite  = r_overwrite;

endmodule

// File: rtl/output_result_buffer.sv
// -----------------------------------------------------------------------------
// output_result_buffer
// Captures accumulator results by address and, on command, streams a
// contiguous (wrapping) address range out over a valid/ready interface.
//   clk, rst        : clock, synchronous active-low reset
//   i_wr_en/addr/data : result writes from the column accumulator
//   i_drain_start   : start a drain (accepted only when idle)
//   i_drain_base    : first entry to drain
//   i_drain_count   : number of entries, saturated to DEPTH
//   o_out           : drained word stream (master side)
//   o_drain_busy    : a drain is in progress (STREAM or DONE)
//   o_drain_done    : one-cycle pulse at the end of a drain
//   o_overwrite     : one-cycle pulse, a write hit an already-valid entry
//   o_valid_bits    : per-entry valid vector
// -----------------------------------------------------------------------------
module output_result_buffer
  import sys_arr_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_wr_en,
  input  addr_t                         i_wr_addr,
  input  data_t                         i_wr_data,
  input  logic                          i_drain_start,
  input  addr_t                         i_drain_base,
  input  cnt_t                          i_drain_count,
  output_result_buffer_if.master        o_out,
  output logic                          o_drain_busy,
  output logic                          o_drain_done,
  output logic                          o_overwrite,
  output logic [DEPTH-1:0]              o_valid_bits
);

  drain_state_t r_state, w_next_state;

  addr_t r_ptr;            // address of the word currently in the out regs
  cnt_t  r_rem;            // words still to hand over, including the current one
  logic  r_out_valid;
  data_t r_out_data;
  addr_t r_out_addr;
  logic  r_out_entry_vld;

  cnt_t  w_count;
  logic  w_start, w_handshake, w_last;
  logic  w_load_first, w_load_next, w_load, w_bypass;
  addr_t w_ptr_next, w_load_addr;
  data_t w_mem_data;
  logic  w_mem_vld;

  assign w_count      = sat_count(i_drain_count);
  assign w_start      = (r_state == IDLE) & i_drain_start;
  assign w_handshake  = (r_state == STREAM) & r_out_valid & o_out.out_ready;
  assign w_last       = (r_rem == cnt_t'(1));
  assign w_load_first = w_start & (w_count != '0);
  assign w_load_next  = w_handshake & ~w_last;
  assign w_load       = w_load_first | w_load_next;
  assign w_ptr_next   = r_ptr + addr_t'(1);   // wraps DEPTH-1 -> 0
  assign w_load_addr  = w_load_first ? i_drain_base : w_ptr_next;

  // A write landing on the entry being loaded this edge is forwarded so the
  // stream never shows the stale word.
  assign w_bypass = i_wr_en & (i_wr_addr == w_load_addr);

  output_buffer_mem u_mem (
    .clk          (clk),
    .rst          (rst),
    .i_wr_en      (i_wr_en),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .i_clr_en     (w_handshake),
    .i_clr_addr   (r_ptr),
    .i_rd_addr    (w_load_addr),
    .o_rd_data    (w_mem_data),
    .o_rd_vld     (w_mem_vld),
    .o_valid_bits (o_valid_bits),
    .o_overwrite  (o_overwrite)
  );

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---- FSM: next state ----
  // NOTE: the default assignment first means no path leaves w_next_state
  // unassigned, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (i_drain_start) w_next_state = (w_count != '0) ? STREAM : DONE;
      STREAM:  if (w_handshake && w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    o_drain_busy = (r_state != IDLE);
    o_drain_done = (r_state == DONE);
  end

  // ---- Pointer, remaining count and output registers ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr           <= '0;
      r_rem           <= '0;
      r_out_valid     <= 1'b0;
      r_out_data      <= '0;
      r_out_addr      <= '0;
      r_out_entry_vld <= 1'b0;
    end else begin
      if (w_load_first) begin
        r_ptr <= i_drain_base;
        r_rem <= w_count;
      end else if (w_handshake) begin
        r_ptr <= w_ptr_next;
        r_rem <= r_rem - cnt_t'(1);
      end

      // Out regs change only on a load; without a handshake they hold.
      if (w_load) begin
        r_out_valid     <= 1'b1;
        r_out_data      <= w_bypass ? i_wr_data : w_mem_data;
        r_out_addr      <= w_load_addr;
        r_out_entry_vld <= w_bypass | w_mem_vld;
      end else if (w_handshake) begin
        r_out_valid     <= 1'b0;
      end
    end
  end

  assign o_out.out_valid     = r_out_valid;
  assign o_out.out_data      = r_out_data;
  assign o_out.out_addr      = r_out_addr;
  assign o_out.out_entry_vld = r_out_entry_vld;

endmodule
